// File: rtl/burst_ctrl.sv
// Burst controller: drives an external phase counter for a configured number of wraps.
// Optional feature macro: BURST_CTRL_PAUSE_EN adds a pause input that freezes the running burst.
module burst_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_incr,
    input  logic [CYC_W-1:0] cfg_cycles,
    input  logic [WIDTH-1:0] count_in,
`ifdef BURST_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic [WIDTH-1:0] cnt_incr,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   incr_q;
    logic [CYC_W-1:0]   cycles_q;
    logic [CYC_W-1:0]   remain_q;
    logic               hs;
    logic               paused;
    logic               carry;
    logic               counted;

`ifdef BURST_CTRL_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    assign hs       = cfg_valid & cfg_ready;
    assign cnt_incr = incr_q;
    assign cnt_en   = (state_q == RUN) & ~paused;
    // Carry out of count_in + cnt_incr, i.e. the (WIDTH+1)-bit sum reaching 2**WIDTH.
    assign carry    = count_in > ~cnt_incr;
    assign wrap     = cnt_en & carry;
    assign counted  = wrap & (|cycles_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        cnt_clr   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (start) state_d = ARM;
            end
            ARM: begin
                busy    = 1'b1;
                cnt_clr = 1'b1;
                state_d = stop ? IDLE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                // stop outranks the final wrap
                if (stop)                                    state_d = IDLE;
                else if (counted && remain_q == CYC_W'(1))   state_d = DONE;
            end
            DONE: begin
                done      = 1'b1;
                cfg_ready = 1'b1;
                if (start)   state_d = ARM;
                else if (hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Configuration registers; a zero step would never wrap, so it is stored as 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            incr_q   <= WIDTH'(1);
            cycles_q <= '0;
        end else if (hs) begin
            incr_q   <= (cfg_incr == '0) ? WIDTH'(1) : cfg_incr;
            cycles_q <= cfg_cycles;
        end
    end

    // Remaining wraps: loaded while arming, so a same-cycle handshake is already visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           remain_q <= '0;
        else if (state_q == ARM)           remain_q <= cycles_q;
        else if (counted && remain_q != '0) remain_q <= remain_q - CYC_W'(1);
    end

endmodule

// File: tb/tb_burst_ctrl.sv
// Directed bench for burst_ctrl with a simple external phase counter attached.
module tb_burst_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_incr;
    logic [15:0] cfg_cycles;
    logic [7:0] count_in;
    logic       cnt_clr;
    logic       cnt_en;
    logic [7:0] cnt_incr;
    logic       wrap;
    logic       busy;
    logic       done;
`ifdef BURST_CTRL_PAUSE_EN
    logic       pause;
`endif

    int vectors;
    int errs;
    int nwrap;
    int wrap_at;
    logic done_seen;

    burst_ctrl #(.WIDTH(8), .CYC_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_incr   (cfg_incr),
        .cfg_cycles (cfg_cycles),
        .count_in   (count_in),
`ifdef BURST_CTRL_PAUSE_EN
        .pause      (pause),
`endif
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .cnt_incr   (cnt_incr),
        .wrap       (wrap),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External counter driven by the controller
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          count_in <= 8'd0;
        else if (cnt_clr) count_in <= 8'd0;
        else if (cnt_en)  count_in <= count_in + cnt_incr;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vectors    = 0;
        errs       = 0;
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        cfg_valid  = 1'b0;
        cfg_incr   = 8'd0;
        cfg_cycles = 16'd0;
`ifdef BURST_CTRL_PAUSE_EN
        pause      = 1'b0;
`endif

        // Reset values
        @(negedge clk); #1;
        chk1("rst_cfg_ready", cfg_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_cnt_en", cnt_en, 1'b0);
        chk1("rst_cnt_clr", cnt_clr, 1'b0);
        chk1("rst_wrap", wrap, 1'b0);
        chkw("rst_cnt_incr", 32'(cnt_incr), 32'd1);
        rst = 1'b0;
        tick();

        // Burst 1: incr=64, cycles=2, handshake together with start
        cfg_valid = 1'b1; cfg_incr = 8'd64; cfg_cycles = 16'd2; start = 1'b1;
        #1;
        chk1("s1_cfg_ready_idle", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        #1;
        chk1("s1_arm_clr", cnt_clr, 1'b1);
        chk1("s1_arm_en", cnt_en, 1'b0);
        chk1("s1_arm_busy", busy, 1'b1);
        chk1("s1_arm_ready", cfg_ready, 1'b0);
        chkw("s1_arm_incr", 32'(cnt_incr), 32'd64);
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk1("s1_run_en", cnt_en, 1'b1);
            chk1("s1_run_clr", cnt_clr, 1'b0);
            chk1("s1_run_wrap", wrap, (i == 3) || (i == 7));
            chk1("s1_run_done", done, 1'b0);
            tick();
        end
        #1;
        chk1("s1_done", done, 1'b1);
        chk1("s1_done_busy", busy, 1'b0);
        chk1("s1_done_en", cnt_en, 1'b0);
        chk1("s1_done_ready", cfg_ready, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        #1;
        chk1("s1_done_ignores_stop", done, 1'b1);

        // Burst 2: incr=0 stored as 1, cycles=1; handshake in DONE returns to IDLE
        cfg_valid = 1'b1; cfg_incr = 8'd0; cfg_cycles = 16'd1;
        tick();
        cfg_valid = 1'b0;
        #1;
        chk1("s2_idle_done", done, 1'b0);
        chk1("s2_idle_busy", busy, 1'b0);
        chkw("s2_incr_one", 32'(cnt_incr), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk1("s2_arm_clr", cnt_clr, 1'b1);
        tick();
        wrap_at = -1;
        for (int i = 0; i < 300 && wrap_at < 0; i++) begin
            #1;
            if (wrap) wrap_at = i;
            tick();
        end
        #1;
        chkw("s2_wrap_cycle", 32'(wrap_at), 32'd255);
        chk1("s2_done", done, 1'b1);

        // Burst 3: continuous (cycles=0), incr=128, stopped after 10 RUN cycles
        cfg_valid = 1'b1; cfg_incr = 8'd128; cfg_cycles = 16'd0; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        #1;
        chkw("s3_arm_incr", 32'(cnt_incr), 32'd128);
        tick();
        nwrap = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (wrap) nwrap++;
            done_seen = done_seen | done;
            tick();
        end
        stop = 1'b1;
        #1;
        chk1("s3_busy_before_stop", busy, 1'b1);
        tick();
        stop = 1'b0;
        #1;
        chkw("s3_wrap_count", 32'(nwrap), 32'd5);
        chk1("s3_done_never", done_seen, 1'b0);
        chk1("s3_after_stop_en", cnt_en, 1'b0);
        chk1("s3_after_stop_busy", busy, 1'b0);
        chk1("s3_after_stop_done", done, 1'b0);
        chk1("s3_after_stop_ready", cfg_ready, 1'b1);

        // Burst 4: stop on the final wrap wins; start during RUN is ignored
        cfg_valid = 1'b1; cfg_incr = 8'd128; cfg_cycles = 16'd1; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        tick();
        start = 1'b1;
        #1;
        chk1("s4_run0_wrap", wrap, 1'b0);
        tick();
        start = 1'b0;
        stop = 1'b1;
        #1;
        chk1("s4_final_wrap", wrap, 1'b1);
        chk1("s4_start_ignored", cnt_clr, 1'b0);
        tick();
        stop = 1'b0;
        #1;
        chk1("s4_no_done", done, 1'b0);
        chk1("s4_idle_busy", busy, 1'b0);
        chk1("s4_idle_ready", cfg_ready, 1'b1);

        // Burst 5: asynchronous reset in the middle of RUN
        cfg_valid = 1'b1; cfg_incr = 8'd32; cfg_cycles = 16'd3; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk1("s5_rst_busy", busy, 1'b0);
        chk1("s5_rst_en", cnt_en, 1'b0);
        chk1("s5_rst_wrap", wrap, 1'b0);
        chk1("s5_rst_done", done, 1'b0);
        chk1("s5_rst_clr", cnt_clr, 1'b0);
        chk1("s5_rst_ready", cfg_ready, 1'b1);
        chkw("s5_rst_incr", 32'(cnt_incr), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk1("s5_rearm_clr", cnt_clr, 1'b1);
        chkw("s5_default_incr", 32'(cnt_incr), 32'd1);
        tick();
        // Default cycles=0: the burst keeps running past a wrap
        for (int i = 0; i < 260; i++) tick();
        #1;
        chk1("s5_continuous_busy", busy, 1'b1);
        chk1("s5_continuous_done", done, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        #1;
        chk1("s5_stopped", busy, 1'b0);

`ifdef BURST_CTRL_PAUSE_EN
        // Pause for 3 RUN cycles delays the single wrap by 3 cycles
        cfg_valid = 1'b1; cfg_incr = 8'd64; cfg_cycles = 16'd1; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        tick();
        #1;
        chk1("p_run0_wrap", wrap, 1'b0);
        tick();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("p_paused_en", cnt_en, 1'b0);
            chk1("p_paused_wrap", wrap, 1'b0);
            chk1("p_paused_busy", busy, 1'b1);
            tick();
        end
        pause = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("p_resume_wrap", wrap, i == 2);
            tick();
        end
        #1;
        chk1("p_done", done, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
